instr_encoder_loader: RTL and testbench
=======================================

Name: instr_encoder_loader

Overview:
- Reverse direction of the single-cycle CPU's opcode decoder: encodes symbolic instruction commands (ADDI, ADD, AUIPC, SW) into RV32I machine words.
- Writes the encoded words sequentially into instruction memory, so benches and boot logic load programs without hand-assembled hex.
- Sits between a command source (testbench or boot sequencer) and the instruction-memory write port.
- One registered output stage with a valid/ready handshake on both sides.

Parameters:
- DATA_WIDTH, 32, instruction and immediate width (fixed at 32 for RV32I).
- DEPTH, 64, maximum number of words per load session.
- BASE_ADDR, 32'h0000_0000, byte address of the first word written.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high reset.
- start  input  1  single-cycle pulse that begins a load session.
- cmd_valid  input  1  command present.
- cmd_ready  output  1  block can accept a command this cycle.
- cmd_op  input  2  00=ADDI, 01=ADD, 10=AUIPC, 11=SW.
- cmd_rd  input  5  destination register (ignored for SW).
- cmd_rs1  input  5  source register 1 (ignored for AUIPC).
- cmd_rs2  input  5  source register 2 (ADD and SW only).
- cmd_imm  input  32  immediate; full 32-bit value, with AUIPC carrying imm[31:12].
- cmd_last  input  1  final command of the session.
- imem_we  output  1  write request (valid).
- imem_ready  input  1  memory accepts the write this cycle.
- imem_addr  output  32  byte address of the write.
- imem_wdata  output  32  encoded instruction.
- loaded_count  output  $clog2(DEPTH+1)  words written in the current session.
- done  output  1  session complete.
- imm_err  output  1  sticky flag: an immediate was out of range.

Behaviour:
- Reset values: cmd_ready=0, imem_we=0, imem_addr=BASE_ADDR, imem_wdata=0, loaded_count=0, done=0, imm_err=0; state=IDLE. A reset in mid-session discards any pending write.
- States:
  - IDLE: start moves to LOAD.
  - LOAD: on a write completion (imem_we && imem_ready), move to DONE if that word was flagged last or loaded_count reaches DEPTH.
  - DONE: start moves back to LOAD.
- Entering LOAD: next address=BASE_ADDR, loaded_count=0, imm_err=0, done=0. start while in LOAD is ignored.
- Handshake rules:
  - cmd_ready = (state==LOAD) && !last_pending && (!imem_we || imem_ready) && (loaded_count + imem_we < DEPTH).
  - A command is accepted when cmd_valid && cmd_ready.
  - The accepted word appears on imem_we/imem_wdata/imem_addr in the next cycle (latency 1).
  - imem_we, imem_addr and imem_wdata are held stable until imem_ready. Back-to-back writes run at one per cycle when imem_ready=1.
- Address and count: imem_addr starts at BASE_ADDR and increments by 4 per accepted command. loaded_count increments on each write completion.
- last_pending:
  - Set when a command with cmd_last=1 is accepted; cleared on entering LOAD.
  - Once set, cmd_ready stays 0.
  - done rises the cycle after that write completes and holds in DONE.
- Encodings (funct3/funct7 per RV32I):
  - ADDI: {imm[11:0], rs1, 000, rd, 0010011}
  - ADD: {0000000, rs2, rs1, 000, rd, 0110011}
  - AUIPC: {imm[31:12], rd, 0010111}
  - SW: {imm[11:5], rs2, rs1, 010, imm[4:0], 0100011}
- imm_err (set on the accept cycle; the word is still written truncated):
  - ADDI/SW: set if imm[31:11] is not all zeros or all ones.
  - AUIPC: set if imm[11:0]!=0.
  - ADD: immediate ignored, never flags.
- Capacity: once DEPTH words are accepted, cmd_ready=0. The session ends on the DEPTH-th completion even without cmd_last.
- Simultaneous cmd_last and the DEPTH-th word: single transition to DONE.
- No commands are accepted in IDLE or DONE.

Test Plan:
- ADDI x1,x0,5 after start with BASE_ADDR=0 -> next cycle imem_we=1, imem_addr=0x0, imem_wdata=0x00500093; loaded_count=1 after ready.
- ADD x3,x1,x2, then AUIPC x5,imm=0x12345000, then SW x2,8(x1) with cmd_last=1, imem_ready=1 -> words 0x002081B3, 0x12345297, 0x0020A423 at addrs 0x0, 0x4, 0x8. done=1 the cycle after the third write; cmd_ready=0 thereafter.
- Hold imem_ready=0 for 3 cycles while a second command waits -> imem_we/addr/wdata unchanged, cmd_ready=0, no command lost or duplicated.
- ADDI with imm=0x800 (2048) -> imm_err=1, wdata=0x80000093 for rd=1, rs1=0. A following start clears imm_err.
- DEPTH=4, stream 6 commands without cmd_last -> exactly 4 writes (0x0–0xC), done=1, commands 5 and 6 stay unaccepted.
- Reset asserted while imem_we=1 in LOAD -> next cycle all outputs at reset values and state=IDLE. A subsequent start restarts at BASE_ADDR.

Source files
------------

// File: rtl/instr_encoder_loader.sv
// Encodes ADDI/ADD/AUIPC/SW commands into RV32I words and streams them to imem.
// Latency 1 cmd->imem; cmd_ready drops while a write is stalled, last is pending, or capacity is reached.
module instr_encoder_loader #(
    parameter int          DATA_WIDTH = 32,
    parameter int          DEPTH      = 64,
    parameter logic [31:0] BASE_ADDR  = 32'h0000_0000
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         start,
    input  logic                         cmd_valid,
    output logic                         cmd_ready,
    input  logic [1:0]                   cmd_op,
    input  logic [4:0]                   cmd_rd,
    input  logic [4:0]                   cmd_rs1,
    input  logic [4:0]                   cmd_rs2,
    input  logic [DATA_WIDTH-1:0]        cmd_imm,
    input  logic                         cmd_last,
    output logic                         imem_we,
    input  logic                         imem_ready,
    output logic [DATA_WIDTH-1:0]        imem_addr,
    output logic [DATA_WIDTH-1:0]        imem_wdata,
    output logic [$clog2(DEPTH+1)-1:0]   loaded_count,
    output logic                         done,
    output logic                         imm_err
);
    localparam int CW = $clog2(DEPTH+1);

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_DONE} state_t;

    state_t                state_q, state_d;
    logic                  imem_we_q, imem_we_d;
    logic [DATA_WIDTH-1:0] imem_addr_q, imem_addr_d;
    logic [DATA_WIDTH-1:0] imem_wdata_q, imem_wdata_d;
    logic [DATA_WIDTH-1:0] next_addr_q, next_addr_d;
    logic [CW-1:0]         loaded_count_q, loaded_count_d;
    logic                  done_q, done_d;
    logic                  imm_err_q, imm_err_d;
    logic                  last_pending_q, last_pending_d;
    logic                  wr_last_q, wr_last_d;

    logic                  wr_done, accept, enter_load, room;
    logic [DATA_WIDTH-1:0] enc_word;
    logic                  enc_bad;

    assign wr_done    = imem_we_q && imem_ready;
    assign accept     = cmd_valid && cmd_ready;
    assign enter_load = start && (state_q != S_LOAD);
    // Count the word still sitting in the output stage so we never overfill.
    assign room       = (int'(loaded_count_q) + int'(imem_we_q)) < DEPTH;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= S_IDLE;
            imem_we_q      <= 1'b0;
            imem_addr_q    <= BASE_ADDR;
            imem_wdata_q   <= '0;
            next_addr_q    <= BASE_ADDR;
            loaded_count_q <= '0;
            done_q         <= 1'b0;
            imm_err_q      <= 1'b0;
            last_pending_q <= 1'b0;
            wr_last_q      <= 1'b0;
        end else begin
            state_q        <= state_d;
            imem_we_q      <= imem_we_d;
            imem_addr_q    <= imem_addr_d;
            imem_wdata_q   <= imem_wdata_d;
            next_addr_q    <= next_addr_d;
            loaded_count_q <= loaded_count_d;
            done_q         <= done_d;
            imm_err_q      <= imm_err_d;
            last_pending_q <= last_pending_d;
            wr_last_q      <= wr_last_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (start) state_d = S_LOAD;
            S_LOAD:  if (wr_done && (wr_last_q || (int'(loaded_count_q) + 1 >= DEPTH)))
                         state_d = S_DONE;
            S_DONE:  if (start) state_d = S_LOAD;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        cmd_ready = (state_q == S_LOAD) && !last_pending_q && (!imem_we_q || imem_ready) && room;
    end

    always_comb begin
        enc_word = '0;
        enc_bad  = 1'b0;
        case (cmd_op)
            2'b00: begin
                enc_word = {cmd_imm[11:0], cmd_rs1, 3'b000, cmd_rd, 7'b0010011};
                enc_bad  = !((&cmd_imm[31:11]) || !(|cmd_imm[31:11]));
            end
            2'b01: enc_word = {7'b0000000, cmd_rs2, cmd_rs1, 3'b000, cmd_rd, 7'b0110011};
            2'b10: begin
                enc_word = {cmd_imm[31:12], cmd_rd, 7'b0010111};
                enc_bad  = |cmd_imm[11:0];
            end
            default: begin
                enc_word = {cmd_imm[11:5], cmd_rs2, cmd_rs1, 3'b010, cmd_imm[4:0], 7'b0100011};
                enc_bad  = !((&cmd_imm[31:11]) || !(|cmd_imm[31:11]));
            end
        endcase
    end

    always_comb begin
        imem_we_d      = imem_we_q;
        imem_addr_d    = imem_addr_q;
        imem_wdata_d   = imem_wdata_q;
        next_addr_d    = next_addr_q;
        loaded_count_d = loaded_count_q;
        done_d         = done_q;
        imm_err_d      = imm_err_q;
        last_pending_d = last_pending_q;
        wr_last_d      = wr_last_q;
        if (enter_load) begin
            imem_addr_d    = BASE_ADDR;
            next_addr_d    = BASE_ADDR;
            loaded_count_d = '0;
            done_d         = 1'b0;
            imm_err_d      = 1'b0;
            last_pending_d = 1'b0;
            wr_last_d      = 1'b0;
        end else begin
            if (wr_done) begin
                imem_we_d      = 1'b0;
                loaded_count_d = loaded_count_q + CW'(1);
                if (state_d == S_DONE) done_d = 1'b1;
            end
            if (accept) begin
                imem_we_d    = 1'b1;
                imem_addr_d  = next_addr_q;
                imem_wdata_d = enc_word;
                next_addr_d  = next_addr_q + 32'd4;
                wr_last_d    = cmd_last;
                if (cmd_last) last_pending_d = 1'b1;
                if (enc_bad)  imm_err_d = 1'b1;
            end
        end
    end

    assign imem_we      = imem_we_q;
    assign imem_addr    = imem_addr_q;
    assign imem_wdata   = imem_wdata_q;
    assign loaded_count = loaded_count_q;
    assign done         = done_q;
    assign imm_err      = imm_err_q;
endmodule

// File: tb/tb_instr_encoder_loader.sv
// Directed bench for instr_encoder_loader (DEPTH=4); a scoreboard queue is checked by a write monitor.
module tb_instr_encoder_loader;
    localparam int DEPTH = 4;
    localparam int CW    = $clog2(DEPTH+1);

    logic          clk = 1'b0;
    logic          reset, start, cmd_valid, cmd_ready, cmd_last;
    logic [1:0]    cmd_op;
    logic [4:0]    cmd_rd, cmd_rs1, cmd_rs2;
    logic [31:0]   cmd_imm;
    logic          imem_we, imem_ready;
    logic [31:0]   imem_addr, imem_wdata;
    logic [CW-1:0] loaded_count;
    logic          done, imm_err;

    instr_encoder_loader #(.DATA_WIDTH(32), .DEPTH(DEPTH), .BASE_ADDR(32'h0)) dut (
        .clk(clk), .reset(reset), .start(start),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
        .cmd_rd(cmd_rd), .cmd_rs1(cmd_rs1), .cmd_rs2(cmd_rs2),
        .cmd_imm(cmd_imm), .cmd_last(cmd_last),
        .imem_we(imem_we), .imem_ready(imem_ready), .imem_addr(imem_addr),
        .imem_wdata(imem_wdata), .loaded_count(loaded_count),
        .done(done), .imm_err(imm_err)
    );

    always #5 clk = ~clk;

    typedef struct { logic [31:0] addr; logic [31:0] data; } exp_t;
    exp_t        sb[$];
    int          n_checks = 0;
    int          n_fail   = 0;
    logic [31:0] exp_addr = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Write monitor: pops one expectation per completed write, checks held outputs during stalls.
    initial begin
        bit          hold = 0;
        logic [31:0] h_addr, h_data;
        exp_t        e;
        forever begin
            @(negedge clk);
            if (reset) begin
                hold = 0;
                continue;
            end
            if (hold) begin
                check("hold_we",   {31'b0, imem_we}, 32'd1);
                check("hold_addr", imem_addr, h_addr);
                check("hold_data", imem_wdata, h_data);
            end
            if (imem_we && imem_ready) begin
                if (sb.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_write: got addr %h data %h, expected none", imem_addr, imem_wdata);
                end else begin
                    e = sb.pop_front();
                    check("wr_addr", imem_addr, e.addr);
                    check("wr_data", imem_wdata, e.data);
                end
            end
            hold   = imem_we && !imem_ready;
            h_addr = imem_addr;
            h_data = imem_wdata;
        end
    end

    task automatic send(input logic [1:0] op, input logic [4:0] rd, input logic [4:0] rs1,
                        input logic [4:0] rs2, input logic [31:0] imm, input logic last,
                        input logic [31:0] word, input int budget, output bit acc);
        exp_t e;
        acc = 0;
        cmd_valid = 1; cmd_op = op; cmd_rd = rd; cmd_rs1 = rs1; cmd_rs2 = rs2;
        cmd_imm = imm; cmd_last = last;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (cmd_ready) begin
                e.addr = exp_addr; e.data = word;
                sb.push_back(e);
                exp_addr += 4;
                acc = 1;
                break;
            end
        end
        @(posedge clk); #1;
        cmd_valid = 0;
    endtask

    task automatic start_session();
        @(posedge clk); #1 start = 1;
        @(posedge clk); #1 start = 0;
        exp_addr = 0;
    endtask

    task automatic wait_done(input string name);
        for (int i = 0; i < 20 && !done; i++) @(negedge clk);
        @(negedge clk);
        check(name, {31'b0, done}, 32'd1);
    endtask

    initial begin
        bit acc;
        reset = 1; start = 0; cmd_valid = 0; cmd_op = 0; cmd_rd = 0; cmd_rs1 = 0;
        cmd_rs2 = 0; cmd_imm = 0; cmd_last = 0; imem_ready = 1;
        repeat (2) @(posedge clk);
        #1 reset = 0;
        @(negedge clk);
        check("rst_cmd_ready", {31'b0, cmd_ready}, 0);
        check("rst_we",        {31'b0, imem_we}, 0);
        check("rst_addr",      imem_addr, 0);
        check("rst_wdata",     imem_wdata, 0);
        check("rst_count",     32'(loaded_count), 0);
        check("rst_done",      {31'b0, done}, 0);
        check("rst_imm_err",   {31'b0, imm_err}, 0);

        // Session 1: ADDI x1,x0,5 as the only (last) word.
        start_session();
        send(2'b00, 5'd1, 5'd0, 5'd0, 32'd5, 1'b1, 32'h0050_0093, 10, acc);
        check("s1_accept", {31'b0, acc}, 1);
        wait_done("s1_done");
        check("s1_count", 32'(loaded_count), 1);

        // Session 2: ADD, AUIPC, SW(last) back to back.
        start_session();
        check("s2_done_clr", {31'b0, done}, 0);
        send(2'b01, 5'd3, 5'd1, 5'd2, 32'd0,         1'b0, 32'h0020_81B3, 10, acc);
        check("s2_acc0", {31'b0, acc}, 1);
        send(2'b10, 5'd5, 5'd0, 5'd0, 32'h1234_5000, 1'b0, 32'h1234_5297, 10, acc);
        check("s2_acc1", {31'b0, acc}, 1);
        send(2'b11, 5'd0, 5'd1, 5'd2, 32'd8,         1'b1, 32'h0020_A423, 10, acc);
        check("s2_acc2", {31'b0, acc}, 1);
        wait_done("s2_done");
        check("s2_count", 32'(loaded_count), 3);
        check("s2_ready_low", {31'b0, cmd_ready}, 0);
        check("s2_imm_err", {31'b0, imm_err}, 0);

        // Session 3: stall for 3 cycles with a command waiting, then an out-of-range ADDI.
        start_session();
        imem_ready = 0;
        send(2'b00, 5'd2, 5'd0, 5'd0, 32'hFFFF_FFFF, 1'b0, 32'hFFF0_0113, 10, acc);
        check("s3_accA", {31'b0, acc}, 1);
        fork
            begin
                send(2'b01, 5'd4, 5'd5, 5'd6, 32'd0, 1'b0, 32'h0062_8233, 20, acc);
                check("s3_accB", {31'b0, acc}, 1);
            end
            begin
                repeat (3) begin
                    @(negedge clk);
                    check("s3_stall_ready", {31'b0, cmd_ready}, 0);
                end
                @(posedge clk); #1 imem_ready = 1;
            end
        join
        check("s3_no_err", {31'b0, imm_err}, 0);
        send(2'b00, 5'd1, 5'd0, 5'd0, 32'h0000_0800, 1'b1, 32'h8000_0093, 10, acc);
        check("s3_accC", {31'b0, acc}, 1);
        @(negedge clk);
        check("s3_imm_err", {31'b0, imm_err}, 1);
        wait_done("s3_done");
        check("s3_count", 32'(loaded_count), 3);

        // Session 4: capacity -- six commands, no last, only four accepted.
        start_session();
        check("s4_err_clr", {31'b0, imm_err}, 0);
        send(2'b11, 5'd0,  5'd2,  5'd3, 32'hFFFF_FFFC, 1'b0, 32'hFE31_2E23, 10, acc);
        check("s4_acc0", {31'b0, acc}, 1);
        send(2'b10, 5'd10, 5'd0,  5'd0, 32'hFFFF_F000, 1'b0, 32'hFFFF_F517, 10, acc);
        check("s4_acc1", {31'b0, acc}, 1);
        send(2'b00, 5'd31, 5'd31, 5'd0, 32'hFFFF_F800, 1'b0, 32'h800F_8F93, 10, acc);
        check("s4_acc2", {31'b0, acc}, 1);
        send(2'b01, 5'd1,  5'd2,  5'd3, 32'd0,         1'b0, 32'h0031_00B3, 10, acc);
        check("s4_acc3", {31'b0, acc}, 1);
        send(2'b00, 5'd1,  5'd0,  5'd0, 32'd1,         1'b0, 32'h0010_0093, 6, acc);
        check("s4_acc4", {31'b0, acc}, 0);
        send(2'b00, 5'd1,  5'd0,  5'd0, 32'd2,         1'b0, 32'h0020_0093, 6, acc);
        check("s4_acc5", {31'b0, acc}, 0);
        wait_done("s4_done");
        check("s4_count", 32'(loaded_count), 4);
        check("s4_imm_err", {31'b0, imm_err}, 0);

        // Session 5: reset while a write is pending, then restart.
        start_session();
        imem_ready = 0;
        send(2'b00, 5'd7, 5'd0, 5'd0, 32'd9, 1'b0, 32'h0090_0393, 10, acc);
        check("s5_acc", {31'b0, acc}, 1);
        @(negedge clk);
        check("s5_we_pending", {31'b0, imem_we}, 1);
        @(posedge clk); #1 reset = 1;
        @(posedge clk); #1 reset = 0;
        sb.delete();
        exp_addr = 0;
        @(negedge clk);
        check("s5_rst_we",    {31'b0, imem_we}, 0);
        check("s5_rst_addr",  imem_addr, 0);
        check("s5_rst_wdata", imem_wdata, 0);
        check("s5_rst_count", 32'(loaded_count), 0);
        check("s5_rst_ready", {31'b0, cmd_ready}, 0);
        imem_ready = 1;
        send(2'b00, 5'd1, 5'd0, 5'd0, 32'd5, 1'b1, 32'h0050_0093, 4, acc);
        check("s5_idle_noacc", {31'b0, acc}, 0);
        start_session();
        send(2'b00, 5'd1, 5'd0, 5'd0, 32'd5, 1'b1, 32'h0050_0093, 10, acc);
        check("s5_restart_acc", {31'b0, acc}, 1);
        wait_done("s5_done");
        check("s5_count", 32'(loaded_count), 1);

        repeat (2) @(negedge clk);
        check("sb_empty", sb.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
